column_readout_ctrl: RTL and testbench

COLUMN_READOUT_CTRL -- requirements
Module: column_readout_ctrl

---
 rtl/column_readout_pkg.sv | 37 +++
 rtl/hit_fifo.sv | 48 ++++
 rtl/column_readout_ctrl.sv | 148 ++++++++++++++
 tb/tb_column_readout_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/column_readout_pkg.sv
// Shared types and constants for the column readout controller.
// TS_GRAY_EN (optional macro): Gray-coded TS broadcast and LE/TE decode.
package column_readout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FRZ  = 3'd1,
        ST_RD   = 3'd2,
        ST_SMP  = 3'd3,
        ST_CLR  = 3'd4,
        ST_CHK  = 3'd5
    } state_e;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] le;
        logic [7:0] te;
        logic [7:0] tot;
    } hit_word_t;

    localparam int CHK_WAIT = 2;
    localparam int WORD_W   = $bits(hit_word_t);

    function automatic logic [7:0] bin2gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [7:0] gray2bin(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/hit_fifo.sv
// First-word-fall-through FIFO for hit words.
// Output reads zero while empty so nothing stale leaks after reset.
module hit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; push and pop may both fire on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/column_readout_ctrl.sv
// Column readout controller: freeze, read, sample, queue hit words.
// TS_GRAY_EN (optional macro): Gray TS output, Gray-decoded LE/TE.
module column_readout_ctrl
    import column_readout_pkg::*;
#(
    parameter int READ_WAIT  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        HB,
    input  logic [7:0]  ADDR_OUT_B,
    input  logic [7:0]  TS_LE_B,
    input  logic [7:0]  TS_TE_B,
    output logic [7:0]  TS,
    output logic        FREEZE,
    output logic        READ,
    output logic [31:0] DATA_OUT,
    output logic        DATA_VALID,
    input  logic        DATA_READY
);

    localparam logic [2:0] IDLE = ST_IDLE;
    localparam logic [2:0] FRZ  = ST_FRZ;
    localparam logic [2:0] RD   = ST_RD;
    localparam logic [2:0] SMP  = ST_SMP;
    localparam logic [2:0] CLR  = ST_CLR;
    localparam logic [2:0] CHK  = ST_CHK;

    localparam logic [3:0] RD_LAST  = 4'(READ_WAIT - 1);
    localparam logic [3:0] CHK_LAST = 4'(CHK_WAIT - 1);

    logic [2:0]  state;
    logic [3:0]  wcnt;
    logic [7:0]  ts_cnt;
    logic        hb_s1;
    logic        hb_s2;
    logic        hit_pending;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic [7:0]  le_v;
    logic [7:0]  te_v;
    hit_word_t   hit_word;

    assign hit_pending = ~hb_s2;

    // Free-running timestamp counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ts_cnt <= '0;
        else     ts_cnt <= ts_cnt + 8'd1;
    end

`ifdef TS_GRAY_EN
    assign TS   = bin2gray(ts_cnt);
    assign le_v = gray2bin(~TS_LE_B);
    assign te_v = gray2bin(~TS_TE_B);
`else
    assign TS   = ts_cnt;
    assign le_v = ~TS_LE_B;
    assign te_v = ~TS_TE_B;
`endif

    // Two-flop synchronizer for the asynchronous hit bus; idles high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hb_s1 <= 1'b1;
            hb_s2 <= 1'b1;
        end else begin
            hb_s1 <= HB;
            hb_s2 <= hb_s1;
        end
    end

    // Assemble the hit word from the inverted pixel buses.
    always_comb begin
        hit_word      = '0;
        hit_word.addr = ~ADDR_OUT_B;
        hit_word.le   = le_v;
        hit_word.te   = te_v;
        hit_word.tot  = te_v - le_v;
    end

    // Readout sequencer; wcnt times the RD and CHK dwell periods.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit_pending) state <= FRZ;
                end
                FRZ: begin
                    state <= RD;
                    wcnt  <= '0;
                end
                RD: begin
                    if (wcnt == RD_LAST) begin
                        state <= SMP;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                SMP: begin
                    if (!fifo_full) state <= CLR;
                end
                CLR: begin
                    state <= CHK;
                    wcnt  <= '0;
                end
                CHK: begin
                    if (wcnt == CHK_LAST) begin
                        wcnt  <= '0;
                        state <= hit_pending ? RD : IDLE;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    assign FREEZE     = (state != IDLE);
    assign READ       = (state == RD) || (state == SMP);
    assign push       = (state == SMP) && !fifo_full;
    assign DATA_VALID = ~fifo_empty;

    hit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .pop   (DATA_READY),
        .wdata (hit_word),
        .rdata (DATA_OUT),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_column_readout_ctrl.sv
// Directed bench for column_readout_ctrl.
// Honours TS_GRAY_EN when the design is built with it.
module tb_column_readout_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        HB = 1'b1;
    logic [7:0]  ADDR_OUT_B = 8'hFF;
    logic [7:0]  TS_LE_B = 8'hFF;
    logic [7:0]  TS_TE_B = 8'hFF;
    logic [7:0]  TS;
    logic        FREEZE;
    logic        READ;
    logic [31:0] DATA_OUT;
    logic        DATA_VALID;
    logic        DATA_READY = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;
    int frz_low = 0;

    logic [7:0]  v_addr [8];
    logic [7:0]  v_le   [8];
    logic [7:0]  v_te   [8];
    logic [31:0] v_word [8];

    column_readout_ctrl #(
        .READ_WAIT  (2),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .HB         (HB),
        .ADDR_OUT_B (ADDR_OUT_B),
        .TS_LE_B    (TS_LE_B),
        .TS_TE_B    (TS_TE_B),
        .TS         (TS),
        .FREEZE     (FREEZE),
        .READ       (READ),
        .DATA_OUT   (DATA_OUT),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] enc(input logic [7:0] v);
`ifdef TS_GRAY_EN
        return v ^ {1'b0, v[7:1]};
`else
        return v;
`endif
    endfunction

    function automatic logic [7:0] dec(input logic [7:0] g);
`ifdef TS_GRAY_EN
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
`else
        return g;
`endif
    endfunction

    task automatic drive_bus(input int i);
        ADDR_OUT_B = ~v_addr[i];
        TS_LE_B    = ~enc(v_le[i]);
        TS_TE_B    = ~enc(v_te[i]);
    endtask

    task automatic wait_read(input logic lvl, input string tag);
        for (int k = 0; k < 100; k++) begin
            @(posedge CLK); #1;
            if (FREEZE === 1'b0) frz_low++;
            if (READ === lvl) break;
        end
        n_cmp++;
        if (READ !== lvl) begin
            n_fail++;
            $display("FAIL %s: READ=%b want %b (timeout)", tag, READ, lvl);
        end
    endtask

    task automatic wait_freeze_low(input string tag);
        for (int k = 0; k < 50; k++) begin
            if (FREEZE === 1'b0) break;
            @(posedge CLK); #1;
        end
        n_cmp++;
        if (FREEZE !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: FREEZE=%b want 0", tag, FREEZE);
        end
    endtask

    task automatic pop_word(input logic [31:0] exp, input string tag);
        n_cmp++;
        if (DATA_VALID !== 1'b1 || DATA_OUT !== exp) begin
            n_fail++;
            $display("FAIL %s: valid=%b data=%h want 1/%h",
                     tag, DATA_VALID, DATA_OUT, exp);
        end
        DATA_READY = 1'b1;
        @(posedge CLK); #1;
        DATA_READY = 1'b0;
    endtask

    // HB held low; bus moves to the next vector at every READ fall.
    task automatic run_queue(input int n, input int first);
        HB = 1'b0;
        drive_bus(first);
        for (int k = 0; k < n; k++) begin
            wait_read(1'b1, "queue_rise");
            if (k == 0) frz_low = 0;
            wait_read(1'b0, "queue_fall");
            if (first + k + 1 < 8) drive_bus(first + k + 1);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #1;
        n_cmp++;
        if (FREEZE !== 0 || READ !== 0 || DATA_VALID !== 0 ||
            DATA_OUT !== 32'h0 || TS !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: frz=%b rd=%b dv=%b do=%h ts=%h want all 0",
                     FREEZE, READ, DATA_VALID, DATA_OUT, TS);
        end
        @(posedge CLK); #1;
        n_cmp++;
        if (TS !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ts_hold: TS=%h want 00", TS);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        n_cmp++;
        if (dec(TS) !== 8'd1) begin
            n_fail++;
            $display("FAIL ts_first: TS=%h want count 1", TS);
        end
    endtask

    task automatic test_ts_wrap();
        logic [7:0] prev;
        logic [7:0] cur;
        int errs = 0;
        bit wrap = 0;
        int gchk = 0;
        prev = dec(TS);
        for (int k = 0; k < 300; k++) begin
            @(posedge CLK); #1;
            cur = dec(TS);
            if (cur !== prev + 8'd1) errs++;
            if (prev == 8'd255 && cur == 8'd0) wrap = 1;
`ifdef TS_GRAY_EN
            if (cur == 8'd5 && TS !== 8'h07) gchk++;
`endif
            prev = cur;
        end
        n_cmp++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL ts_incr: %0d bad steps want 0", errs);
        end
        n_cmp++;
        if (!wrap) begin
            n_fail++;
            $display("FAIL ts_wrap: wrap=%b want 1", wrap);
        end
        n_cmp++;
        if (gchk != 0) begin
            n_fail++;
            $display("FAIL ts_gray5: %0d bad codes want 0", gchk);
        end
    endtask

    task automatic test_single(input int i, input string tag);
        int rc;
        HB = 1'b0;
        drive_bus(i);
        wait_read(1'b1, tag);
        rc = 1;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK); #1;
            if (READ !== 1'b1) break;
            rc++;
        end
        HB = 1'b1;
        n_cmp++;
        if (rc != 3) begin
            n_fail++;
            $display("FAIL %s_read_len: %0d cycles want 3", tag, rc);
        end
        n_cmp++;
        if (FREEZE !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_clr_freeze: FREEZE=%b want 1", tag, FREEZE);
        end
        wait_freeze_low(tag);
        n_cmp++;
        if (READ !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_read: READ=%b want 0", tag, READ);
        end
        pop_word(v_word[i], tag);
        n_cmp++;
        if (DATA_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: DATA_VALID=%b want 0", tag, DATA_VALID);
        end
    endtask

    task automatic test_two_hits();
        run_queue(2, 1);
        HB = 1'b1;
        n_cmp++;
        if (frz_low != 0) begin
            n_fail++;
            $display("FAIL two_freeze: low %0d cycles want 0", frz_low);
        end
        wait_freeze_low("two_idle");
        pop_word(v_word[1], "two_w0_wrap");
        pop_word(v_word[2], "two_w1");
        n_cmp++;
        if (DATA_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL two_drain: DATA_VALID=%b want 0", DATA_VALID);
        end
    endtask

    task automatic fill_and_hold(input string tag);
        int held = 0;
        run_queue(4, 3);
        wait_read(1'b1, tag);
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK); #1;
            if (READ === 1'b1) held++;
        end
        n_cmp++;
        if (held != 10) begin
            n_fail++;
            $display("FAIL %s_hold: READ high %0d want 10", tag, held);
        end
        n_cmp++;
        if (DATA_OUT !== v_word[3]) begin
            n_fail++;
            $display("FAIL %s_stable: data=%h want %h",
                     tag, DATA_OUT, v_word[3]);
        end
    endtask

    task automatic test_backpressure();
        fill_and_hold("bp");
        HB = 1'b1;
        for (int i = 3; i < 8; i++) pop_word(v_word[i], "bp_pop");
        n_cmp++;
        if (DATA_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: DATA_VALID=%b want 0", DATA_VALID);
        end
        wait_freeze_low("bp_idle");
    endtask

    task automatic test_reset_mid_smp();
        int dv = 0;
        fill_and_hold("rst");
        RST = 1'b1;
        #1;
        n_cmp++;
        if (FREEZE !== 0 || READ !== 0 || DATA_VALID !== 0 ||
            DATA_OUT !== 32'h0 || TS !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid: frz=%b rd=%b dv=%b do=%h ts=%h want 0",
                     FREEZE, READ, DATA_VALID, DATA_OUT, TS);
        end
        HB = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK); #1;
            if (DATA_VALID !== 1'b0 || FREEZE !== 1'b0) dv++;
        end
        n_cmp++;
        if (dv != 0) begin
            n_fail++;
            $display("FAIL rst_after: %0d busy cycles want 0", dv);
        end
        test_single(0, "rst_restart");
    endtask

    initial begin
        v_addr[0] = 8'h2A; v_le[0] = 8'd10;  v_te[0] = 8'd25;
        v_word[0] = 32'h2A0A190F;
        v_addr[1] = 8'h11; v_le[1] = 8'd250; v_te[1] = 8'd3;
        v_word[1] = 32'h11FA0309;
        v_addr[2] = 8'h5C; v_le[2] = 8'd100; v_te[2] = 8'd200;
        v_word[2] = 32'h5C64C864;
        v_addr[3] = 8'h01; v_le[3] = 8'd1;   v_te[3] = 8'd2;
        v_word[3] = 32'h01010201;
        v_addr[4] = 8'h02; v_le[4] = 8'd10;  v_te[4] = 8'd5;
        v_word[4] = 32'h020A05FB;
        v_addr[5] = 8'h03; v_le[5] = 8'd0;   v_te[5] = 8'd255;
        v_word[5] = 32'h0300FFFF;
        v_addr[6] = 8'h04; v_le[6] = 8'd128; v_te[6] = 8'd128;
        v_word[6] = 32'h04808000;
        v_addr[7] = 8'h05; v_le[7] = 8'd7;   v_te[7] = 8'd17;
        v_word[7] = 32'h0507110A;

        test_reset();
        test_ts_wrap();
        test_single(0, "single");
        test_two_hits();
        test_backpressure();
        test_reset_mid_smp();
`ifdef TS_GRAY_EN
        v_addr[0] = 8'h33; v_le[0] = 8'd40; v_te[0] = 8'd45;
        v_word[0] = 32'h33282D05;
        test_single(0, "gray");
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
